// File: rtl/uart_instr_prefetch.sv
// uart_instr_prefetch: instruction fetch engine in front of the bitty core.
// A fetch sends FETCH_CMD and the address byte to the host over the shared
// UART, then collects the instruction's high and low bytes. Define ICACHE_EN
// to add an 8-line direct-mapped cache that serves repeated addresses
// without using the UART.
module uart_instr_prefetch #(
    parameter logic [7:0] FETCH_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  address,
    input  logic        stop_for_rw,
    input  logic        flush,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] instr_out,
    output logic        done,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE,
        CHK,
        SEND_CMD,
        WAIT_CMD,
        SEND_ADDR,
        WAIT_ADDR,
        RECV_HI,
        RECV_LO,
        FILL,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  addr_q;
    logic [7:0]  hi_q;
    logic        cache_hit;
    logic [15:0] hit_data;

`ifdef ICACHE_EN
    logic [7:0]  valid_q;
    logic [4:0]  tag_q  [8];
    logic [15:0] data_q [8];
    logic [2:0]  index;

    assign index     = addr_q[2:0];
    assign cache_hit = valid_q[index] && (tag_q[index] == addr_q[7:3]);
    assign hit_data  = data_q[index];

    // Valid bits: flush clears every line, but a line being filled this cycle stays valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= '0;
            end
            if (state == FILL) begin
                valid_q[index] <= 1'b1;
            end
        end
    end

    // Tag and data storage, written once the full word has been received
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tag_q[index]  <= addr_q[7:3];
            data_q[index] <= instr_out;
        end
    end
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign cache_hit    = 1'b0;
    assign hit_data     = 16'h0000;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and UART/handshake outputs decoded from the current state
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && !stop_for_rw) begin
                    state_next = CHK;
                end
            end
            CHK: begin
                state_next = cache_hit ? DONE : SEND_CMD;
            end
            SEND_CMD: begin
                tx_start   = 1'b1;
                tx_data    = FETCH_CMD;
                state_next = WAIT_CMD;
            end
            WAIT_CMD: begin
                tx_data = FETCH_CMD;
                if (tx_done) begin
                    state_next = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                tx_start   = 1'b1;
                tx_data    = addr_q;
                state_next = WAIT_ADDR;
            end
            WAIT_ADDR: begin
                tx_data = addr_q;
                if (tx_done) begin
                    state_next = RECV_HI;
                end
            end
            RECV_HI: begin
                if (rx_done) begin
                    state_next = RECV_LO;
                end
            end
            RECV_LO: begin
                if (rx_done) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address capture, high-byte holding register and the instruction output
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q    <= 8'h00;
            hi_q      <= 8'h00;
            instr_out <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop_for_rw) begin
                        addr_q <= address;
                    end
                end
                CHK: begin
                    if (cache_hit) begin
                        instr_out <= hit_data;
                    end
                end
                RECV_HI: begin
                    if (rx_done) begin
                        hi_q <= rx_data;
                    end
                end
                RECV_LO: begin
                    if (rx_done) begin
                        instr_out <= {hi_q, rx_data};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_instr_prefetch.sv
// tb_uart_instr_prefetch: self-checking bench for uart_instr_prefetch.
// A table of fetches is replayed against a scripted host; expected words are
// queued when a fetch starts and checked when done pulses. Cache-dependent
// expectations follow the ICACHE_EN macro.
module tb_uart_instr_prefetch;

    localparam logic [7:0] FETCH_CMD = 8'h03;
`ifdef ICACHE_EN
    localparam bit CACHE_BUILT = 1'b1;
`else
    localparam bit CACHE_BUILT = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         stray;
        bit         flushFirst;
        bit         flushAtFill;
        bit         hitIfCached;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  address = 8'h00;
    logic        stop_for_rw = 1'b0;
    logic        flush = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] instr_out;
    logic        done;
    logic        busy;

    int          compared = 0;
    int          mismatched = 0;
    int          txCount = 0;
    int          doneCount = 0;
    int          overlapCount = 0;
    logic [15:0] doneWord = 16'h0000;
    logic [7:0]  txBytes[$];
    logic [15:0] expQ[$];
    vec_t        vecs[14];

    uart_instr_prefetch #(.FETCH_CMD(FETCH_CMD)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .address(address),
        .stop_for_rw(stop_for_rw),
        .flush(flush),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .tx_done(tx_done),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .instr_out(instr_out),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Passive monitor: logs every transmitted byte and every done pulse
    always @(negedge clk) begin
        if (tx_start) begin
            txCount++;
            txBytes.push_back(tx_data);
        end
        if (done) begin
            doneCount++;
            doneWord = instr_out;
        end
        if (tx_start && done) begin
            overlapCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete fetch with a scripted host answering over the UART
    task automatic applyStimulus(input vec_t v);
        int          txBase;
        int          doneBase;
        bit          expHit;
        logic [15:0] word;
        logic [15:0] got;
        txBase   = txCount;
        doneBase = doneCount;
        expHit   = CACHE_BUILT && v.hitIfCached;
        word     = {v.hi, v.lo};
        if (v.flushFirst) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        expQ.push_back(word);
        start   = 1'b1;
        address = v.addr;
        tick();
        start   = 1'b0;
        address = 8'h00;
        checkOutput("busy_chk", 16'(busy), 16'h1);
        tick();
        if (expHit) begin
            checkOutput("hit_done", 16'(done), 16'h1);
            checkOutput("hit_tx_start", 16'(tx_start), 16'h0);
            checkOutput("hit_instr", instr_out, word);
        end else begin
            checkOutput("cmd_tx_start", 16'(tx_start), 16'h1);
            checkOutput("cmd_tx_data", 16'(tx_data), 16'(FETCH_CMD));
            tick();
            checkOutput("cmd_pulse_len", 16'(tx_start), 16'h0);
            if (v.stray) begin
                rx_done = 1'b1;
                rx_data = 8'hFF;
            end
            tick();
            rx_done = 1'b0;
            rx_data = 8'h00;
            tick();
            checkOutput("cmd_hold", 16'(tx_data), 16'(FETCH_CMD));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            checkOutput("addr_tx_start", 16'(tx_start), 16'h1);
            checkOutput("addr_tx_data", 16'(tx_data), 16'(v.addr));
            if (v.stray) begin
                rx_done = 1'b1;
                rx_data = 8'hEE;
            end
            tick();
            rx_done = 1'b0;
            rx_data = 8'h00;
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            checkOutput("recv_tx_data", 16'(tx_data), 16'h0);
            tick();
            rx_done = 1'b1;
            rx_data = v.hi;
            tick();
            rx_done = 1'b0;
            rx_data = 8'h00;
            tick();
            rx_done = 1'b1;
            rx_data = v.lo;
            tick();
            rx_done = 1'b0;
            rx_data = 8'h00;
            if (v.flushAtFill) begin
                flush = 1'b1;
            end
            checkOutput("instr_early", instr_out, word);
            checkOutput("done_early", 16'(done), 16'h0);
            tick();
            flush = 1'b0;
            checkOutput("miss_done", 16'(done), 16'h1);
            checkOutput("done_no_tx", 16'(tx_start), 16'h0);
        end
        tick();
        checkOutput("busy_idle", 16'(busy), 16'h0);
        checkOutput("done_pulse_len", 16'(done), 16'h0);
        checkOutput("done_count", 16'(doneCount - doneBase), 16'h1);
        got = expQ.pop_front();
        checkOutput("scoreboard_word", doneWord, got);
        if (expHit) begin
            checkOutput("hit_tx_count", 16'(txCount - txBase), 16'h0);
        end else begin
            checkOutput("miss_tx_count", 16'(txCount - txBase), 16'h2);
            if (txBytes.size() >= txBase + 2) begin
                checkOutput("miss_byte_cmd", 16'(txBytes[txBase]), 16'(FETCH_CMD));
                checkOutput("miss_byte_addr", 16'(txBytes[txBase + 1]), 16'(v.addr));
            end
        end
    endtask

    initial begin
        vecs[0]  = '{8'h2A, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h05, 8'hAB, 8'hCD, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h05, 8'hAB, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8'h2A, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h32, 8'hBE, 8'hEF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h2A, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h32, 8'hBE, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h32, 8'hBE, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h05, 8'hAB, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h05, 8'hAB, 8'hCD, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};

        $display("[TB] reset state");
        reset = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rst_tx_start", 16'(tx_start), 16'h0);
        checkOutput("rst_tx_data", 16'(tx_data), 16'h0);
        checkOutput("rst_instr", instr_out, 16'h0000);
        checkOutput("rst_done", 16'(done), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        reset = 1'b1;
        tick();

        $display("[TB] start gated by stop_for_rw");
        stop_for_rw = 1'b1;
        start       = 1'b1;
        address     = 8'h77;
        tick();
        checkOutput("gate_busy0", 16'(busy), 16'h0);
        tick();
        start       = 1'b0;
        stop_for_rw = 1'b0;
        checkOutput("gate_busy1", 16'(busy), 16'h0);
        tick();
        tick();
        checkOutput("gate_busy2", 16'(busy), 16'h0);
        checkOutput("gate_no_tx", 16'(txCount), 16'h0);

        $display("[TB] fetch table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset while waiting for the high byte");
        begin
            int doneBase;
            doneBase = doneCount;
            start    = 1'b1;
            address  = 8'h40;
            tick();
            start    = 1'b0;
            tick();
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            checkOutput("mid_busy", 16'(busy), 16'h1);
            checkOutput("mid_tx_data", 16'(tx_data), 16'h0);
            reset = 1'b0;
            tick();
            tick();
            checkOutput("mid_rst_tx_start", 16'(tx_start), 16'h0);
            checkOutput("mid_rst_tx_data", 16'(tx_data), 16'h0);
            checkOutput("mid_rst_instr", instr_out, 16'h0000);
            checkOutput("mid_rst_done", 16'(done), 16'h0);
            checkOutput("mid_rst_busy", 16'(busy), 16'h0);
            reset = 1'b1;
            tick();
            tick();
            checkOutput("mid_rst_idle", 16'(busy), 16'h0);
            checkOutput("mid_rst_no_done", 16'(doneCount - doneBase), 16'h0);
        end

        $display("[TB] fetch after reset misses");
        applyStimulus('{8'h2A, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0});

        checkOutput("tx_done_overlap", 16'(overlapCount), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
